// File: rtl/irq_controller_if.sv
// Signal bundle between the interrupt controller and its surroundings (sources, mask, core handshake).
// The slave modport is the controller's view; the master modport is the view of whatever drives it.
interface irq_controller_if #(
  parameter int NSRC = 8,
  parameter int IDW  = 3,
  parameter int CW   = 8
);
  logic [NSRC-1:0] irq_src;
  logic [NSRC-1:0] irq_mask;
  logic            ExtlAck;
  logic            ExtIRQ;
  logic [IDW-1:0]  irq_id;
  logic [NSRC-1:0] irq_pending;
  logic [CW-1:0]   irq_lost_cnt;

  modport slave (
    input  irq_src, irq_mask, ExtlAck,
    output ExtIRQ, irq_id, irq_pending, irq_lost_cnt
  );

  modport master (
    output irq_src, irq_mask, ExtlAck,
    input  ExtIRQ, irq_id, irq_pending, irq_lost_cnt
  );
endinterface

// File: rtl/irq_controller.sv
// External interrupt controller: synchronises and edge-detects sources, holds pending events,
// and presents the lowest-index unmasked event to the core with an ExtIRQ/ExtlAck handshake.
module irq_controller #(
  parameter int NSRC = 8,
  parameter int IDW  = 3,
  parameter int CW   = 8
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  irq_controller_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, REQ, ACKWAIT} stateT;

  stateT           stateReg, stateNext;
  logic            extIrqReg, extIrqNext;
  logic [IDW-1:0]  irqIdReg, irqIdNext;
  logic [NSRC-1:0] pendingReg, pendingNext;
  logic [CW-1:0]   lostCntReg, lostCntNext;
  logic [NSRC-1:0] srcEdge;
  logic [NSRC-1:0] clearVec;
  logic [NSRC-1:0] eligible;
  logic [IDW-1:0]  winner;
  logic            anyLoss;

  // Two flops resolve metastability; the third gives the previous level for edge detection.
  for (genvar gi = 0; gi < NSRC; gi++) begin : gSync
    logic [2:0] syncReg;
    always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) syncReg <= '0;
      else       syncReg <= {syncReg[1:0], bus.irq_src[gi]};
    end
    assign srcEdge[gi] = syncReg[1] & ~syncReg[2];
  end

  always_comb begin
    clearVec = '0;
    if (stateReg == REQ && bus.ExtlAck) clearVec[irqIdReg] = 1'b1;
  end

  // A new edge on the source being cleared survives: the OR comes after the clear.
  assign pendingNext = (pendingReg & ~clearVec) | srcEdge;
  assign anyLoss     = |(srcEdge & pendingReg & ~clearVec);
  assign lostCntNext = (anyLoss && lostCntReg != {CW{1'b1}}) ? lostCntReg + 1'b1 : lostCntReg;
  assign eligible    = pendingReg & bus.irq_mask;

  always_comb begin
    winner = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (eligible[i]) winner = IDW'(i);
    end
  end

  always_comb begin
    stateNext  = stateReg;
    extIrqNext = extIrqReg;
    irqIdNext  = irqIdReg;
    unique case (stateReg)
      IDLE: begin
        extIrqNext = 1'b0;
        if (|eligible) begin
          irqIdNext  = winner;
          extIrqNext = 1'b1;
          stateNext  = REQ;
        end
      end
      REQ: begin
        extIrqNext = 1'b1;
        if (bus.ExtlAck) begin
          extIrqNext = 1'b0;
          stateNext  = ACKWAIT;
        end
      end
      ACKWAIT: begin
        extIrqNext = 1'b0;
        if (!bus.ExtlAck) stateNext = IDLE;
      end
      default: begin
        extIrqNext = 1'b0;
        stateNext  = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      stateReg   <= IDLE;
      extIrqReg  <= 1'b0;
      irqIdReg   <= '0;
      pendingReg <= '0;
      lostCntReg <= '0;
    end else begin
      stateReg   <= stateNext;
      extIrqReg  <= extIrqNext;
      irqIdReg   <= irqIdNext;
      pendingReg <= pendingNext;
      lostCntReg <= lostCntNext;
    end
  end

  assign bus.ExtIRQ       = extIrqReg;
  assign bus.irq_id       = irqIdReg;
  assign bus.irq_pending  = pendingReg;
  assign bus.irq_lost_cnt = lostCntReg;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: one task per scenario, inline checks against hand-computed values.
`timescale 1ns/1ps
module tb_irq_controller;
  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;
  int   passCnt  = 0;
  int   totalCnt = 0;

  irq_controller_if #(.NSRC(8), .IDW(3), .CW(8)) bus ();

  irq_controller #(.NSRC(8), .IDW(3), .CW(8)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus.slave)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passCnt++;
  endtask

  task automatic ackOnce();
    bus.ExtlAck = 1'b1;
    tick();
    bus.ExtlAck = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    bus.irq_src  = '0;
    bus.irq_mask = '0;
    bus.ExtlAck  = 1'b0;
    #20 reset = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("reset_extirq", 32'(bus.ExtIRQ), 32'h0);
      chk("reset_pending", 32'(bus.irq_pending), 32'h0);
      chk("reset_lost", 32'(bus.irq_lost_cnt), 32'h0);
      tick();
    end
    chk("reset_id", 32'(bus.irq_id), 32'h0);
    $display("reset: ExtIRQ=%0b pending=%02h lost=%0d", bus.ExtIRQ, bus.irq_pending, bus.irq_lost_cnt);
  endtask

  task automatic test_single();
    bus.irq_mask = 8'hFF;
    bus.irq_src  = 8'h20;
    tick(2);
    bus.irq_src  = 8'h00;
    tick();
    chk("single_pending_k2", 32'(bus.irq_pending), 32'h20);
    chk("single_noirq_k2", 32'(bus.ExtIRQ), 32'h0);
    tick();
    chk("single_extirq_k3", 32'(bus.ExtIRQ), 32'h1);
    chk("single_id", 32'(bus.irq_id), 32'h5);
    bus.ExtlAck = 1'b1;
    tick();
    chk("single_pending_clr", 32'(bus.irq_pending), 32'h0);
    chk("single_extirq_drop", 32'(bus.ExtIRQ), 32'h0);
    bus.ExtlAck = 1'b0;
    tick(2);
    chk("single_idle", 32'(bus.ExtIRQ), 32'h0);
    $display("single: src5 requested id=5 and retired");
  endtask

  task automatic test_priority();
    bus.irq_src = 8'h44;
    tick(2);
    bus.irq_src = 8'h00;
    tick(2);
    chk("prio_pending", 32'(bus.irq_pending), 32'h44);
    chk("prio_first_irq", 32'(bus.ExtIRQ), 32'h1);
    chk("prio_first_id", 32'(bus.irq_id), 32'h2);
    bus.ExtlAck = 1'b1;
    tick();
    chk("prio_after_ack", 32'(bus.irq_pending), 32'h40);
    bus.ExtlAck = 1'b0;
    tick();
    chk("prio_gap", 32'(bus.ExtIRQ), 32'h0);
    tick();
    chk("prio_second_irq", 32'(bus.ExtIRQ), 32'h1);
    chk("prio_second_id", 32'(bus.irq_id), 32'h6);
    ackOnce();
    chk("prio_pending_end", 32'(bus.irq_pending), 32'h0);
    $display("priority: id=2 then id=6 (back-to-back)");
  endtask

  task automatic test_held_ack();
    bus.irq_src = 8'h09;
    tick(2);
    bus.irq_src = 8'h00;
    tick(2);
    chk("held_first_id", 32'(bus.irq_id), 32'h0);
    bus.ExtlAck = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("held_pending", 32'(bus.irq_pending), 32'h08);
      chk("held_extirq", 32'(bus.ExtIRQ), 32'h0);
    end
    bus.ExtlAck = 1'b0;
    tick(2);
    chk("held_next_irq", 32'(bus.ExtIRQ), 32'h1);
    chk("held_next_id", 32'(bus.irq_id), 32'h3);
    ackOnce();
    $display("held_ack: one event retired per ack");
  endtask

  task automatic test_mask();
    bus.irq_mask = 8'hFB;
    bus.irq_src  = 8'h04;
    tick(2);
    bus.irq_src  = 8'h00;
    tick(4);
    chk("mask_pending", 32'(bus.irq_pending), 32'h04);
    chk("mask_noirq", 32'(bus.ExtIRQ), 32'h0);
    bus.irq_mask = 8'hFF;
    tick();
    chk("unmask_irq", 32'(bus.ExtIRQ), 32'h1);
    chk("unmask_id", 32'(bus.irq_id), 32'h2);
    ackOnce();
    chk("mask_pending_end", 32'(bus.irq_pending), 32'h0);
    $display("mask: masked src2 latched, requested after unmask");
  endtask

  task automatic test_lost();
    for (int p = 0; p < 3; p++) begin
      bus.irq_src = 8'h02;
      tick(2);
      bus.irq_src = 8'h00;
      tick(2);
    end
    tick();
    chk("lost_pending", 32'(bus.irq_pending), 32'h02);
    chk("lost_cnt", 32'(bus.irq_lost_cnt), 32'h2);
    chk("lost_irq", 32'(bus.ExtIRQ), 32'h1);
    chk("lost_id", 32'(bus.irq_id), 32'h1);
    // Edge reaches the pending register on the same edge that samples the ack.
    bus.irq_src = 8'h02;
    tick(2);
    bus.ExtlAck = 1'b1;
    tick();
    chk("setwins_pending", 32'(bus.irq_pending), 32'h02);
    chk("setwins_lost", 32'(bus.irq_lost_cnt), 32'h2);
    chk("setwins_drop", 32'(bus.ExtIRQ), 32'h0);
    bus.ExtlAck = 1'b0;
    bus.irq_src = 8'h00;
    tick(2);
    chk("setwins_rereq", 32'(bus.ExtIRQ), 32'h1);
    chk("setwins_id", 32'(bus.irq_id), 32'h1);
    $display("lost: cnt=%0d pending=%02h", bus.irq_lost_cnt, bus.irq_pending);
  endtask

  task automatic test_reset_mid_req();
    chk("midreq_pre", 32'(bus.ExtIRQ), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("midreq_async_drop", 32'(bus.ExtIRQ), 32'h0);
    chk("midreq_pending", 32'(bus.irq_pending), 32'h0);
    chk("midreq_lost", 32'(bus.irq_lost_cnt), 32'h0);
    tick();
    reset = 1'b0;
    tick(3);
    chk("midreq_after_irq", 32'(bus.ExtIRQ), 32'h0);
    chk("midreq_after_pending", 32'(bus.irq_pending), 32'h0);
    // A fresh event must be serviced normally, proving the FSM restarted in IDLE.
    bus.irq_src = 8'h80;
    tick(2);
    bus.irq_src = 8'h00;
    tick(2);
    chk("midreq_restart_irq", 32'(bus.ExtIRQ), 32'h1);
    chk("midreq_restart_id", 32'(bus.irq_id), 32'h7);
    ackOnce();
    $display("reset_mid_req: ExtIRQ dropped asynchronously, state cleared");
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_held_ack();
    test_mask();
    test_lost();
    test_reset_mid_req();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
